// File: rtl/cl_vio_led_ctrl.sv
// Virtual DIP debounce + LED display controller (swap / blink / event count / walk).
// Build option: define CL_VIO_LED_DEB_EN to enable the per-bit debounce counters.

module cl_vio_led_lane #(
  parameter int DEB_CYCLES = 16
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic din_i,
  output logic stable_o,
  output logic pulse_o
);
  if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_bad_deb
    $error("DEB_CYCLES out of range");
  end

  logic [1:0] sync_q;
  logic       stable_q, pulse_q;
  logic       upd;

`ifdef CL_VIO_LED_DEB_EN
  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;

  // Count only while the synced bit disagrees; any agreement restarts the run.
  always_comb begin
    cnt_d = '0;
    upd   = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == DEB_LAST) upd   = 1'b1;
      else                   cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign upd = (sync_q[1] != stable_q);
`endif

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], din_i};
      pulse_q <= upd;
      if (upd) stable_q <= sync_q[1];
    end
  end

  assign stable_o = stable_q;
  assign pulse_o  = pulse_q;
endmodule

module cl_vio_led_ctrl #(
  parameter int NUM_SW      = 16,
  parameter int DEB_CYCLES  = 16,
  parameter int BLINK_DIV_W = 24
) (
  input  logic              clk_main_a0,
  input  logic              rst_main_n,
  input  logic [NUM_SW-1:0] sh_cl_status_vdip,
  input  logic [1:0]        led_mode,
  output logic [NUM_SW-1:0] cl_sh_status_vled,
  output logic [NUM_SW-1:0] dip_stable,
  output logic [NUM_SW-1:0] dip_chg_pulse,
  output logic              blink_tick
);
  localparam int NIB = NUM_SW / 4;

  if (NUM_SW < 4 || NUM_SW > 32 || (NUM_SW % 4) != 0) begin : g_bad_sw
    $error("NUM_SW must be a multiple of 4 in 4..32");
  end

  typedef enum logic [1:0] {
    M_SWAP  = 2'd0,
    M_BLINK = 2'd1,
    M_COUNT = 2'd2,
    M_WALK  = 2'd3
  } mode_e;

  logic [NUM_SW-1:0]      stable, pulse;
  logic [BLINK_DIV_W-1:0] pre_q;
  logic                   tick_q, phase_q;
  mode_e                  mode_q;
  logic [NUM_SW-1:0]      walk_q, ev_q, vled_q, vled_d, swap;
  logic                   wrap, mode_chg;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_lane
    cl_vio_led_lane #(.DEB_CYCLES(DEB_CYCLES)) u_lane (
      .gclk     (clk_main_a0),
      .grst_n   (rst_main_n),
      .din_i    (sh_cl_status_vdip[i]),
      .stable_o (stable[i]),
      .pulse_o  (pulse[i])
    );
  end

  for (genvar k = 0; k < NIB; k++) begin : g_swap
    assign swap[4*(NIB-1-k) +: 4] = stable[4*k +: 4];
  end

  assign wrap     = &pre_q;
  assign mode_chg = (led_mode != mode_q);

  always_comb begin
    vled_d = '0;
    case (mode_q)
      M_SWAP:  vled_d = swap;
      M_BLINK: vled_d = stable & {NUM_SW{phase_q}};
      M_COUNT: vled_d = ev_q;
      M_WALK:  vled_d = walk_q;
      default: vled_d = '0;
    endcase
  end

  // Mode change wins over a coincident tick: walk reloads and phase clears.
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      pre_q   <= '0;
      tick_q  <= 1'b0;
      phase_q <= 1'b0;
      mode_q  <= M_SWAP;
      walk_q  <= NUM_SW'(1);
      ev_q    <= '0;
      vled_q  <= '0;
    end else begin
      pre_q  <= pre_q + 1'b1;
      tick_q <= wrap;
      mode_q <= mode_e'(led_mode);
      vled_q <= vled_d;
      if (|pulse) ev_q <= ev_q + 1'b1;
      if (mode_chg) begin
        walk_q  <= NUM_SW'(1);
        phase_q <= 1'b0;
      end else if (wrap) begin
        walk_q  <= {walk_q[NUM_SW-2:0], walk_q[NUM_SW-1]};
        phase_q <= ~phase_q;
      end
    end
  end

  assign cl_sh_status_vled = vled_q;
  assign dip_stable        = stable;
  assign dip_chg_pulse     = pulse;
  assign blink_tick        = tick_q;
endmodule

// File: tb/tb_cl_vio_led_ctrl.sv
// Directed bench for cl_vio_led_ctrl: a 16-lane instance with a fast prescaler,
// plus a 4-lane instance used to reach the event-counter wrap quickly.

module tb_cl_vio_led_ctrl;
  localparam int DEB = 16;
`ifdef CL_VIO_LED_DEB_EN
  localparam int LAT = DEB + 2;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] vdip = '0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] vled, stable, pulse;
  logic        tick;

  logic [3:0]  vdip4 = '0;
  logic [1:0]  mode4 = 2'd2;
  logic [3:0]  vled4, stable4, pulse4;
  logic        tick4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cl_vio_led_ctrl #(.NUM_SW(16), .DEB_CYCLES(DEB), .BLINK_DIV_W(4)) u_dut (
    .clk_main_a0       (clk),
    .rst_main_n        (rst_n),
    .sh_cl_status_vdip (vdip),
    .led_mode          (mode),
    .cl_sh_status_vled (vled),
    .dip_stable        (stable),
    .dip_chg_pulse     (pulse),
    .blink_tick        (tick)
  );

  cl_vio_led_ctrl #(.NUM_SW(4), .DEB_CYCLES(1), .BLINK_DIV_W(4)) u_dut4 (
    .clk_main_a0       (clk),
    .rst_main_n        (rst_n),
    .sh_cl_status_vdip (vdip4),
    .led_mode          (mode4),
    .cl_sh_status_vled (vled4),
    .dip_stable        (stable4),
    .dip_chg_pulse     (pulse4),
    .blink_tick        (tick4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then park on the falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] exp;
    logic        found;
    int          npulse;

    // Reset state
    #12;
    chk("rst_vled",   vled,   16'h0);
    chk("rst_stable", stable, 16'h0);
    chk("rst_pulse",  pulse,  16'h0);
    chk("rst_tick",   tick,   1'b0);
    chk("rst_vled4",  vled4,  4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);

    // Swap mode, 0x1234 accepted after LAT edges, shown one edge later
    vdip = 16'h1234;
    step(LAT - 1);
    chk("deb_early_stable", stable, 16'h0);
    chk("deb_early_pulse",  pulse,  16'h0);
    step(1);
    chk("deb_stable", stable, 16'h1234);
    chk("deb_pulse",  pulse,  16'h1234);
    chk("deb_vled_lag", vled, 16'h0);
    step(1);
    chk("swap_vled",   vled,  16'h4321);
    chk("pulse_clear", pulse, 16'h0);

    // Bit 0 glitch for 10 cycles
    npulse = 0;
    vdip = 16'h1235;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) vdip = 16'h1234;
      step(1);
      if (pulse[0]) npulse++;
`ifdef CL_VIO_LED_DEB_EN
      chk("glitch_state", {stable, pulse, vled}, {16'h1234, 16'h0, 16'h4321});
`endif
    end
`ifdef CL_VIO_LED_DEB_EN
    chk("glitch_npulse", npulse, 0);
`else
    chk("glitch_npulse", npulse, 2);
`endif
    chk("glitch_final", stable, 16'h1234);

    // Walk mode
    mode = 2'd3;
    step(2);
    chk("walk_load", vled, 16'h0001);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (tick) found = 1'b1;
      else step(1);
    end
    chk("walk_tick_seen", found, 1'b1);
    exp = 16'h0002;
    step(1);
    chk("walk_step", vled, exp);
    for (int s = 0; s < 15; s++) begin
      step(16);
      exp = {exp[14:0], exp[15]};
      chk("walk_step", vled, exp);
    end
    chk("walk_wrapped", vled, 16'h0001);
    step(32);
    chk("walk_mid", vled, 16'h0004);
    mode = 2'd0;
    step(2);
    chk("walk_to_swap", vled, 16'h4321);
    mode = 2'd3;
    step(2);
    chk("walk_reload", vled, 16'h0001);

    // Blink mode with 0x00FF
    mode = 2'd0;
    vdip = 16'h00FF;
    step(LAT + 2);
    chk("swap_00ff", vled, 16'hFF00);
    mode = 2'd1;
    step(1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1);
      if (tick) found = 1'b1;
    end
    chk("blink_tick_seen", found, 1'b1);
    chk("blink_off0", vled, 16'h0000);
    step(1);
    chk("blink_on1",  vled, 16'h00FF);
    step(16);
    chk("blink_off1", vled, 16'h0000);
    step(16);
    chk("blink_on2",  vled, 16'h00FF);
    step(16);
    chk("blink_off2", vled, 16'h0000);

    // Reset 5 cycles into a debounce
    mode = 2'd0;
    step(2);
    vdip = 16'h0F0F;
    step(5);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {vled, stable, pulse, 15'h0, tick}, 64'h0);
    step(2);
    rst_n = 1'b1;
    npulse = 0;
    for (int i = 1; i < LAT; i++) begin
      step(1);
      if (pulse != 16'h0 || stable != 16'h0) npulse++;
    end
    chk("postrst_quiet", npulse, 0);
    step(1);
    chk("postrst_stable", stable, 16'h0F0F);
    chk("postrst_pulse",  pulse,  16'h0F0F);
    step(1);
    chk("postrst_vled", vled, 16'hF0F0);

    // Event counter: bits 0 and 1 toggled together count once
    rst_n = 1'b0;
    vdip  = 16'h0;
    mode  = 2'd2;
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("cnt_zero", vled, 16'h0);
    for (int t = 1; t <= 3; t++) begin
      vdip = vdip ^ 16'h0003;
      step(LAT + 3);
      chk("cnt_pair", vled, 16'(t));
    end

    // 4-lane instance: counter wraps from all-ones to 0
    chk("cnt4_zero", vled4, 4'h0);
    for (int t = 1; t <= 15; t++) begin
      vdip4 = vdip4 ^ 4'h1;
      step(6);
      if (t == 8) chk("cnt4_mid", vled4, 4'h8);
    end
    chk("cnt4_full", vled4, 4'hF);
    vdip4 = vdip4 ^ 4'h1;
    step(6);
    chk("cnt4_wrap", vled4, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
